// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered, handshaked instruction decode stage with memory sequencing
module decode_stage #(
  parameter int INSTR_W     = 8,
  parameter int REG_W       = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-REG_W-1:0] opcode,
  output logic [REG_W-1:0]         register,
  output logic [REG_W-1:0]         imm,
  output logic                     is_alu_op,
  output logic                     is_mem_op,
  output logic                     mem_rw,
  output logic                     illegal,
  input  logic                     mem_done,
  output logic                     increment_pc,
  output logic                     mem_timeout
);

  localparam int OPC_W = INSTR_W - REG_W;
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  localparam logic [OPC_W-1:0] OPC_LI  = OPC_W'(5'b00001);
  localparam logic [OPC_W-1:0] OPC_LD  = OPC_W'(5'b00010);
  localparam logic [OPC_W-1:0] OPC_ST  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OPC_INC = OPC_W'(5'b10001);

  typedef enum logic [1:0] {IDLE, FULL, MEM_WAIT} state_t;

  state_t           state, state_nxt;
  logic [OPC_W-1:0] opc_in;
  logic [REG_W-1:0] fld_in;
  logic             dec_li, dec_ld, dec_st, dec_inc;
  logic             accept, alu_retire, mem_fire, tmo_fire;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_retire_q, mem_timeout_q;

  assign opc_in  = instr[INSTR_W-1:REG_W];
  assign fld_in  = instr[REG_W-1:0];
  assign dec_li  = (opc_in == OPC_LI);
  assign dec_ld  = (opc_in == OPC_LD);
  assign dec_st  = (opc_in == OPC_ST);
  assign dec_inc = (opc_in == OPC_INC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = FULL;
      FULL:     if (out_ready) begin
                  if (is_mem_op)   state_nxt = MEM_WAIT;
                  else if (!accept) state_nxt = IDLE;
                end
      MEM_WAIT: if (mem_fire || tmo_fire) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // in_ready is gated by reset so fetch never sees a ready stage while held in reset
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    alu_retire   = 1'b0;
    mem_fire     = 1'b0;
    tmo_fire     = 1'b0;
    case (state)
      IDLE:     in_ready = reset;
      FULL: begin
        out_valid  = 1'b1;
        alu_retire = out_ready & ~is_mem_op;
        in_ready   = reset & alu_retire;
      end
      MEM_WAIT: begin
        mem_fire = mem_done;
        tmo_fire = TMO_EN & ~mem_done & (wait_cnt == CNT_LAST);
      end
      default: ;
    endcase
    accept       = in_valid & in_ready;
    increment_pc = alu_retire | mem_retire_q;
    mem_timeout  = mem_timeout_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode    <= '0;
      register  <= '0;
      imm       <= '0;
      is_alu_op <= 1'b0;
      is_mem_op <= 1'b0;
      mem_rw    <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      opcode    <= opc_in;
      register  <= fld_in;
      imm       <= (dec_li || dec_inc) ? fld_in : '0;
      is_alu_op <= opc_in[OPC_W-1];
      is_mem_op <= dec_ld | dec_st;
      mem_rw    <= opc_in[0];
      illegal   <= ~(dec_li | dec_ld | dec_st | dec_inc);
    end
  end

  // Counter only runs while waiting on memory; it restarts from zero on every entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt      <= '0;
      mem_retire_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      mem_retire_q  <= mem_fire;
      mem_timeout_q <= tmo_fire;
      if (state == MEM_WAIT && !mem_fire && !tmo_fire && TMO_EN) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction decode stage. It sits between the fetch stage and the execute/memory stages of the CPU.
- It generalises the single-cycle decoder: instruction and register-field widths are parameters, there is a valid/ready input and output, and illegal opcodes are flagged.
- Memory operations are sequenced: a LD/ST holds the stage until memory completes, with an optional timeout. The PC advances only when an instruction retires.

Parameters:
- INSTR_W, 8: instruction width. The opcode is instr[INSTR_W-1:REG_W].
- REG_W, 3: width of the register/immediate field instr[REG_W-1:0]. The opcode width is OPC_W = INSTR_W-REG_W. OPC_W must be >= 5.
- MEM_TIMEOUT, 15: maximum number of cycles in MEM_WAIT before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- in_valid  in  1  fetch presents instr.
- in_ready  out  1  stage can accept instr this cycle.
- instr  in  INSTR_W  instruction word.
- out_valid  out  1  decoded fields are valid.
- out_ready  in  1  execute stage accepts the decoded fields.
- opcode  out  OPC_W  registered instr[INSTR_W-1:REG_W].
- register  out  REG_W  registered instr[REG_W-1:0].
- imm  out  REG_W  register field for LI/INC, otherwise 0.
- is_alu_op  out  1  opcode MSB set.
- is_mem_op  out  1  opcode is LD or ST.
- mem_rw  out  1  opcode[0]: 0 = load, 1 = store. Meaningful only when is_mem_op=1.
- illegal  out  1  opcode is not LI, LD, ST or INC.
- mem_done  in  1  memory completion strobe, sampled only in MEM_WAIT.
- increment_pc  out  1  one-cycle retire pulse.
- mem_timeout  out  1  one-cycle abort pulse.

Behaviour:
- Opcodes, zero-extended to OPC_W: LI=00001, LD=00010, ST=00011, INC=10001.
- All decoded outputs are registered at acceptance (in_valid & in_ready) and held stable until the next acceptance.
- Async reset (reset=0) clears all state:
  - state=IDLE, all decoded outputs 0.
  - out_valid=0, increment_pc=0, mem_timeout=0, timeout counter=0.
  - in_ready=0 while reset=0.
- States:
  - IDLE: in_ready=1. On acceptance -> FULL.
  - FULL: out_valid=1. On out_ready:
    - Non-mem op: increment_pc pulses in that same cycle. If in_valid is also 1, the new instr is accepted in the same cycle (in_ready = out_ready & !is_mem_op) and the state stays FULL; otherwise -> IDLE.
    - Mem op: -> MEM_WAIT. No PC pulse and no new accept.
  - MEM_WAIT: out_valid=0, in_ready=0, decoded fields held. The counter increments each cycle.
    - mem_done=1: increment_pc pulses next cycle, -> IDLE, counter cleared.
    - Counter reaches MEM_TIMEOUT (MEM_TIMEOUT>0) with mem_done=0: mem_timeout pulses, -> IDLE, no PC pulse.
    - mem_done and timeout in the same cycle: mem_done wins.
- Illegal opcodes decode normally (is_mem_op=0, imm=0) with illegal=1 and retire with increment_pc like ALU ops.
- mem_done outside MEM_WAIT is ignored.
- Reset mid-MEM_WAIT aborts silently: no increment_pc, no mem_timeout.
- Counter width is clog2(MEM_TIMEOUT+1); no wrap is possible.
- Latency: instr accepted at edge N gives out_valid at N+1. ALU retire coincides with the out handshake; mem retire is 1 cycle after mem_done.

Test Plan:
- Reset, then instr=8'b00001_101 (LI r5), out_ready=1:
  - opcode=00001, register=5, imm=5, is_alu_op=0, is_mem_op=0.
  - increment_pc pulses exactly once, on the handshake cycle.
- Back-to-back INC (8'b10001_011) and LI with out_ready=1 and in_valid held:
  - one instruction per cycle, is_alu_op=1 for INC, imm=3.
  - two increment_pc pulses on consecutive cycles.
- LD r2 (8'b00010_010), then mem_done after 4 cycles:
  - is_mem_op=1, mem_rw=0.
  - in_ready=0 throughout MEM_WAIT.
  - increment_pc exactly 1 cycle after mem_done; the next instr is accepted afterwards.
- ST with mem_done never asserted, MEM_TIMEOUT=15:
  - mem_rw=1.
  - mem_timeout pulses after 15 MEM_WAIT cycles, no increment_pc, state returns to IDLE.
- Illegal opcode 8'b11111_000:
  - illegal=1, imm=0, is_mem_op=0, retires with increment_pc.
- out_ready=0 stall, then reset=0 asserted while in MEM_WAIT:
  - while stalled, fields are held and in_ready=0.
  - on reset, all outputs go to 0 immediately (asynchronously), with no stray pulses.
- Re-run the stall and LD tests with INSTR_W=12, REG_W=4: decode fields scale correctly.
